// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundle between the Y86 pipeline datapath and its hazard controller.
//   master : pipeline side, drives start + stage state, receives stage controls
//   slave  : controller side
//   Stage state : start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
//                 M_icode, m_stat, W_stat
//   Controls    : F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//                 cc_en, halted, final_stat
interface pipe_hazard_ctrl_if;
   logic       start;
   logic [3:0] D_icode;
   logic [3:0] d_srcA;
   logic [3:0] d_srcB;
   logic [3:0] E_icode;
   logic [3:0] E_dstM;
   logic       e_Cnd;
   logic [3:0] M_icode;
   logic [2:0] m_stat;
   logic [2:0] W_stat;

   logic       F_stall;
   logic       D_stall;
   logic       D_bubble;
   logic       E_bubble;
   logic       M_bubble;
   logic       W_stall;
   logic       cc_en;
   logic       halted;
   logic [2:0] final_stat;

   modport master (
      output start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
             m_stat, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cc_en,
             halted, final_stat
   );

   modport slave (
      input  start, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
             m_stat, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cc_en,
             halted, final_stat
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the five-stage Y86 pipeline.
//   Stage controls are combinational from the current stage state; a small
//   IDLE/RUN/DRAIN/HALTED machine gates them so the pipe starts on command
//   and freezes after an exception retires.
// Ports
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   hz     : pipe_hazard_ctrl_if.slave (stage state in, stage controls out)
//   perf_* : CNT_W saturating counters, only with PIPE_PERF_CNT_EN defined
// Build option
//   PIPE_PERF_CNT_EN : adds perf_cycles/perf_stalls/perf_bubbles/perf_mispred
module pipe_hazard_ctrl
`ifdef PIPE_PERF_CNT_EN
   #(parameter int CNT_W = 32)
`endif
(
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   perf_cycles,
   output logic [CNT_W-1:0]   perf_stalls,
   output logic [CNT_W-1:0]   perf_bubbles,
   output logic [CNT_W-1:0]   perf_mispred
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

   state_t     state, state_nxt;
   logic       drain_cnt;     // set after the first DRAIN cycle
   logic [2:0] drain_stat;    // m_stat captured on DRAIN entry
   logic [2:0] final_stat_q;

   logic loaduse, ret, mispred, mexc, wexc;

   assign loaduse = (hz.E_icode == 4'd5 || hz.E_icode == 4'd11) && hz.E_dstM != 4'hF &&
                    (hz.E_dstM == hz.d_srcA || hz.E_dstM == hz.d_srcB);
   assign ret     = hz.D_icode == 4'd9 || hz.E_icode == 4'd9 || hz.M_icode == 4'd9;
   assign mispred = hz.E_icode == 4'd7 && !hz.e_Cnd;
   assign mexc    = hz.m_stat inside {3'd1, 3'd2, 3'd3};
   assign wexc    = hz.W_stat inside {3'd1, 3'd2, 3'd3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         drain_cnt    <= 1'b0;
         drain_stat   <= 3'd0;
         final_stat_q <= 3'd0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= (state == DRAIN);
         if (state == RUN && state_nxt == DRAIN)
            drain_stat <= hz.m_stat;
         // A retiring exception names the halt cause; otherwise the drain
         // timed out and the captured memory-stage status stands in.
         if (state != HALTED && state_nxt == HALTED)
            final_stat_q <= wexc ? hz.W_stat : drain_stat;
      end
   end

   always_comb begin
      state_nxt   = state;
      hz.F_stall  = 1'b0;
      hz.D_stall  = 1'b0;
      hz.D_bubble = 1'b0;
      hz.E_bubble = 1'b0;
      hz.M_bubble = 1'b0;
      hz.W_stall  = 1'b0;
      hz.cc_en    = 1'b0;
      hz.halted   = 1'b0;
      case (state)
         IDLE: begin
            hz.F_stall  = 1'b1;
            hz.D_bubble = 1'b1;
            hz.E_bubble = 1'b1;
            hz.M_bubble = 1'b1;
            if (hz.start) state_nxt = RUN;
         end
         RUN, DRAIN: begin
            hz.F_stall  = loaduse || ret;
            hz.D_stall  = loaduse;
            // stall takes precedence over bubble in D
            hz.D_bubble = (mispred || ret) && !loaduse;
            hz.E_bubble = mispred || loaduse;
            hz.M_bubble = mexc || wexc;
            hz.W_stall  = wexc;
            hz.cc_en    = (state == RUN) && hz.E_icode == 4'd6 && !mexc && !wexc;
            if (wexc)
               state_nxt = HALTED;
            else if (state == RUN && mexc)
               state_nxt = DRAIN;
            else if (state == DRAIN && drain_cnt)
               state_nxt = HALTED;
         end
         default: begin
            hz.F_stall  = 1'b1;
            hz.D_stall  = 1'b1;
            hz.E_bubble = 1'b1;
            hz.M_bubble = 1'b1;
            hz.W_stall  = 1'b1;
            hz.halted   = 1'b1;
         end
      endcase
   end

   assign hz.final_stat = final_stat_q;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic active;
   assign active = (state == RUN) || (state == DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles  <= '0;
         perf_stalls  <= '0;
         perf_bubbles <= '0;
         perf_mispred <= '0;
      end else if (active) begin
         if (!(&perf_cycles))                  perf_cycles  <= perf_cycles + CNT_ONE;
         if (hz.F_stall  && !(&perf_stalls))   perf_stalls  <= perf_stalls + CNT_ONE;
         if (hz.E_bubble && !(&perf_bubbles))  perf_bubbles <= perf_bubbles + CNT_ONE;
         if (mispred     && !(&perf_mispred))  perf_mispred <= perf_mispred + CNT_ONE;
      end
   end
`endif

endmodule
